// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// state encoding, forwarding-select codes and default widths.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_WIDTH        = 5;
  localparam int unsigned CNT_WIDTH        = 16;
  localparam int unsigned DMEM_TIMEOUT_DEF = 255;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_MDU_WAIT  = 2'd2,
    ST_FLUSH     = 2'd3
  } hazState_e;

  typedef struct packed {
    logic ifS;
    logic idS;
    logic exS;
    logic memS;
    logic wbS;
  } stallVec_t;

  typedef struct packed {
    logic ifF;
    logic idF;
    logic exF;
    logic memF;
  } flushVec_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: register indices, busy flags in,
// per-stage stall/flush, forwarding selects and status out.
interface pipeline_hazard_ctrl_if
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_WIDTH,
  parameter int unsigned CNT_W = CNT_WIDTH
);
  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic             ID_NeedRsByID;
  logic             ID_NeedRtByID;
  logic             ID_NeedRsByEX;
  logic             ID_NeedRtByEX;
  logic [REG_W-1:0] EX_Rs;
  logic [REG_W-1:0] EX_Rt;
  logic [REG_W-1:0] EX_RtRd;
  logic             EX_RegWrite;
  logic             EX_MemRead;
  logic [REG_W-1:0] MEM_RtRd;
  logic             MEM_RegWrite;
  logic             MEM_MemRead;
  logic [REG_W-1:0] WB_RtRd;
  logic             WB_RegWrite;
  logic             IF_MemBusy;
  logic             MEM_MemBusy;
  logic             EX_ALUBusy;
  logic             Exc_Req;

  logic             IF_Stall;
  logic             ID_Stall;
  logic             EX_Stall;
  logic             MEM_Stall;
  logic             WB_Stall;
  logic             IF_Flush;
  logic             ID_Flush;
  logic             EX_Flush;
  logic             MEM_Flush;
  logic [1:0]       ID_FwdRs;
  logic [1:0]       ID_FwdRt;
  logic [1:0]       EX_FwdRs;
  logic [1:0]       EX_FwdRt;
  logic             PC_Redirect;
  logic             BusErr;
  logic [CNT_W-1:0] StallCount;

  // Datapath side
  modport master (
    output ID_Rs, ID_Rt, ID_NeedRsByID, ID_NeedRtByID, ID_NeedRsByEX, ID_NeedRtByEX,
    output EX_Rs, EX_Rt, EX_RtRd, EX_RegWrite, EX_MemRead,
    output MEM_RtRd, MEM_RegWrite, MEM_MemRead, WB_RtRd, WB_RegWrite,
    output IF_MemBusy, MEM_MemBusy, EX_ALUBusy, Exc_Req,
    input  IF_Stall, ID_Stall, EX_Stall, MEM_Stall, WB_Stall,
    input  IF_Flush, ID_Flush, EX_Flush, MEM_Flush,
    input  ID_FwdRs, ID_FwdRt, EX_FwdRs, EX_FwdRt,
    input  PC_Redirect, BusErr, StallCount
  );

  // Controller side
  modport slave (
    input  ID_Rs, ID_Rt, ID_NeedRsByID, ID_NeedRtByID, ID_NeedRsByEX, ID_NeedRtByEX,
    input  EX_Rs, EX_Rt, EX_RtRd, EX_RegWrite, EX_MemRead,
    input  MEM_RtRd, MEM_RegWrite, MEM_MemRead, WB_RtRd, WB_RegWrite,
    input  IF_MemBusy, MEM_MemBusy, EX_ALUBusy, Exc_Req,
    output IF_Stall, ID_Stall, EX_Stall, MEM_Stall, WB_Stall,
    output IF_Flush, ID_Flush, EX_Flush, MEM_Flush,
    output ID_FwdRs, ID_FwdRt, EX_FwdRs, EX_FwdRt,
    output PC_Redirect, BusErr, StallCount
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Forwarding select for one source register: MEM ALU result beats WB data;
// loads in MEM are not forwardable and register 0 never matches.
module pipeline_hazard_ctrl_fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_WIDTH
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] memRtRd,
  input  logic             memRegWrite,
  input  logic             memMemRead,
  input  logic [REG_W-1:0] wbRtRd,
  input  logic             wbRegWrite,
  output logic [1:0]       fwdSel_c
);

  always_comb begin
    fwdSel_c = FWD_RF;
    if (memRegWrite && !memMemRead && (memRtRd != '0) && (memRtRd == src)) begin
      fwdSel_c = FWD_MEM;
    end else if (wbRegWrite && (wbRtRd != '0) && (wbRtRd == src)) begin
      fwdSel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage pipeline registers: hazard
// detection, multi-cycle DMEM/MDU holds, DMEM timeout and exception flush.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W        = REG_WIDTH,
  parameter int unsigned CNT_W        = CNT_WIDTH,
  parameter int unsigned DMEM_TIMEOUT = DMEM_TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  pipeline_hazard_ctrl_if.slave     hz
);

  localparam int unsigned TMO_W = $clog2(DMEM_TIMEOUT + 1);

  hazState_e        state;
  hazState_e        stateNxt;
  stallVec_t        stall;
  flushVec_t        flush;
  logic             pcRedirect;
  logic             busErrSet;
  logic             busErr;
  logic [TMO_W-1:0] tmoCtr;
  logic [TMO_W-1:0] tmoNxt;
  logic [CNT_W-1:0] stallCnt;
  logic             loadUse_c;
  logic             branchHaz_c;
  logic [1:0]       fwdIdRs_c;
  logic [1:0]       fwdIdRt_c;
  logic [1:0]       fwdExRs_c;
  logic [1:0]       fwdExRt_c;

  function automatic logic regHit(input logic [REG_W-1:0] src,
                                  input logic [REG_W-1:0] dst,
                                  input logic             en);
    return en && (dst != '0) && (src == dst);
  endfunction

  // Hazards seen by the instruction sitting in ID
  always_comb begin
    loadUse_c   = hz.EX_MemRead &&
                  ((hz.ID_NeedRsByEX && regHit(hz.ID_Rs, hz.EX_RtRd, 1'b1)) ||
                   (hz.ID_NeedRtByEX && regHit(hz.ID_Rt, hz.EX_RtRd, 1'b1)));
    branchHaz_c = (hz.ID_NeedRsByID &&
                   (regHit(hz.ID_Rs, hz.EX_RtRd, hz.EX_RegWrite) ||
                    regHit(hz.ID_Rs, hz.MEM_RtRd, hz.MEM_MemRead))) ||
                  (hz.ID_NeedRtByID &&
                   (regHit(hz.ID_Rt, hz.EX_RtRd, hz.EX_RegWrite) ||
                    regHit(hz.ID_Rt, hz.MEM_RtRd, hz.MEM_MemRead)));
  end

  pipeline_hazard_ctrl_fwd_unit #(.REG_W(REG_W)) u_fwdIdRs (
    .src(hz.ID_Rs), .memRtRd(hz.MEM_RtRd), .memRegWrite(hz.MEM_RegWrite),
    .memMemRead(hz.MEM_MemRead), .wbRtRd(hz.WB_RtRd), .wbRegWrite(hz.WB_RegWrite),
    .fwdSel_c(fwdIdRs_c)
  );

  pipeline_hazard_ctrl_fwd_unit #(.REG_W(REG_W)) u_fwdIdRt (
    .src(hz.ID_Rt), .memRtRd(hz.MEM_RtRd), .memRegWrite(hz.MEM_RegWrite),
    .memMemRead(hz.MEM_MemRead), .wbRtRd(hz.WB_RtRd), .wbRegWrite(hz.WB_RegWrite),
    .fwdSel_c(fwdIdRt_c)
  );

  pipeline_hazard_ctrl_fwd_unit #(.REG_W(REG_W)) u_fwdExRs (
    .src(hz.EX_Rs), .memRtRd(hz.MEM_RtRd), .memRegWrite(hz.MEM_RegWrite),
    .memMemRead(hz.MEM_MemRead), .wbRtRd(hz.WB_RtRd), .wbRegWrite(hz.WB_RegWrite),
    .fwdSel_c(fwdExRs_c)
  );

  pipeline_hazard_ctrl_fwd_unit #(.REG_W(REG_W)) u_fwdExRt (
    .src(hz.EX_Rt), .memRtRd(hz.MEM_RtRd), .memRegWrite(hz.MEM_RegWrite),
    .memMemRead(hz.MEM_MemRead), .wbRtRd(hz.WB_RtRd), .wbRegWrite(hz.WB_RegWrite),
    .fwdSel_c(fwdExRt_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= stateNxt;
    end
  end

  // Stalls follow the busy inputs in the same cycle, so a hold releases
  // the cycle the busy source drops; the state only tracks what is pending.
  always_comb begin
    stateNxt   = state;
    stall      = '0;
    flush      = '0;
    pcRedirect = 1'b0;
    busErrSet  = 1'b0;
    tmoNxt     = '0;
    case (state)
      ST_FLUSH: begin
        flush      = '1;
        pcRedirect = 1'b1;
        stateNxt   = ST_RUN;
      end
      default: begin
        if (hz.Exc_Req) begin
          stateNxt = ST_FLUSH;
        end else if (hz.MEM_MemBusy) begin
          stall = '{ifS: 1'b1, idS: 1'b1, exS: 1'b1, memS: 1'b1, wbS: 1'b0};
          if (tmoCtr == TMO_W'(DMEM_TIMEOUT - 1)) begin
            stateNxt  = ST_FLUSH;
            busErrSet = 1'b1;
          end else begin
            stateNxt = ST_DMEM_WAIT;
            tmoNxt   = tmoCtr + 1'b1;
          end
        end else if (hz.EX_ALUBusy) begin
          stall    = '{ifS: 1'b1, idS: 1'b1, exS: 1'b1, memS: 1'b0, wbS: 1'b0};
          stateNxt = ST_MDU_WAIT;
        end else begin
          stateNxt = ST_RUN;
          if (loadUse_c || branchHaz_c) begin
            stall.ifS = 1'b1;
            stall.idS = 1'b1;
          end else if (hz.IF_MemBusy) begin
            stall.ifS = 1'b1;
          end
        end
      end
    endcase
  end

  // DMEM timeout counter, sticky bus error and saturating stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmoCtr   <= '0;
      busErr   <= 1'b0;
      stallCnt <= '0;
    end else begin
      tmoCtr <= tmoNxt;
      if (busErrSet) begin
        busErr <= 1'b1;
      end
      if ((|stall) && (stallCnt != '1)) begin
        stallCnt <= stallCnt + 1'b1;
      end
    end
  end

  // Everything is forced quiet while reset is held, independent of the clock
  assign hz.IF_Stall    = rst & stall.ifS;
  assign hz.ID_Stall    = rst & stall.idS;
  assign hz.EX_Stall    = rst & stall.exS;
  assign hz.MEM_Stall   = rst & stall.memS;
  assign hz.WB_Stall    = rst & stall.wbS;
  assign hz.IF_Flush    = rst & flush.ifF;
  assign hz.ID_Flush    = rst & flush.idF;
  assign hz.EX_Flush    = rst & flush.exF;
  assign hz.MEM_Flush   = rst & flush.memF;
  assign hz.PC_Redirect = rst & pcRedirect;
  assign hz.ID_FwdRs    = rst ? fwdIdRs_c : FWD_RF;
  assign hz.ID_FwdRt    = rst ? fwdIdRt_c : FWD_RF;
  assign hz.EX_FwdRs    = rst ? fwdExRs_c : FWD_RF;
  assign hz.EX_FwdRt    = rst ? fwdExRt_c : FWD_RF;
  assign hz.BusErr      = busErr;
  assign hz.StallCount  = stallCnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazards, forwarding priority,
// DMEM/MDU holds, timeout, exception flush and async reset.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   nCmp;
  int   nBad;
  int   expCnt;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stall order {IF,ID,EX,MEM,WB}; flush order {IF,ID,EX,MEM}
  task automatic chkStall(input string tag, input logic [4:0] exp);
    chk(tag, 32'({hz.IF_Stall, hz.ID_Stall, hz.EX_Stall, hz.MEM_Stall, hz.WB_Stall}), 32'(exp));
  endtask

  task automatic chkFlush(input string tag, input logic [3:0] exp, input logic expPc);
    chk(tag, 32'({hz.IF_Flush, hz.ID_Flush, hz.EX_Flush, hz.MEM_Flush, hz.PC_Redirect}),
        32'({exp, expPc}));
  endtask

  task automatic idle();
    hz.ID_Rs = '0;         hz.ID_Rt = '0;
    hz.ID_NeedRsByID = 0;  hz.ID_NeedRtByID = 0;
    hz.ID_NeedRsByEX = 0;  hz.ID_NeedRtByEX = 0;
    hz.EX_Rs = '0;         hz.EX_Rt = '0;       hz.EX_RtRd = '0;
    hz.EX_RegWrite = 0;    hz.EX_MemRead = 0;
    hz.MEM_RtRd = '0;      hz.MEM_RegWrite = 0; hz.MEM_MemRead = 0;
    hz.WB_RtRd = '0;       hz.WB_RegWrite = 0;
    hz.IF_MemBusy = 0;     hz.MEM_MemBusy = 0;  hz.EX_ALUBusy = 0;
    hz.Exc_Req = 0;
  endtask

  // Inputs change just after the rising edge; checks run on the falling edge
  task automatic nextCycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    nCmp = 0;
    nBad = 0;
    expCnt = 0;
    rst = 1'b0;
    idle();
    hz.MEM_MemBusy = 1;
    hz.Exc_Req = 1;
    hz.MEM_RtRd = 5'd3; hz.MEM_RegWrite = 1; hz.EX_Rs = 5'd3;
    @(negedge clk);
    chkStall("rst_stall", 5'b00000);
    chkFlush("rst_flush", 4'b0000, 1'b0);
    chk("rst_fwd", 32'(hz.EX_FwdRs), 32'(FWD_RF));
    chk("rst_buserr", 32'(hz.BusErr), 32'd0);
    chk("rst_cnt", 32'(hz.StallCount), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chkFlush("rst_exc_ignored", 4'b0000, 1'b0);

    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    chkStall("idle_stall", 5'b00000);
    chkFlush("idle_flush", 4'b0000, 1'b0);

    // lw $2 in EX, add needs $2 in EX
    nextCycle();
    hz.EX_MemRead = 1; hz.EX_RegWrite = 1; hz.EX_RtRd = 5'd2;
    hz.ID_Rs = 5'd2; hz.ID_NeedRsByEX = 1;
    @(negedge clk);
    chkStall("loaduse_stall", 5'b11000);
    expCnt += 1;
    nextCycle();
    hz.MEM_RtRd = 5'd2; hz.MEM_RegWrite = 1; hz.MEM_MemRead = 1;
    hz.ID_Rs = 5'd2; hz.ID_NeedRsByEX = 1;
    @(negedge clk);
    chkStall("loaduse_release", 5'b00000);
    chk("loaduse_idfwd_noload", 32'(hz.ID_FwdRs), 32'(FWD_RF));
    nextCycle();
    hz.WB_RtRd = 5'd2; hz.WB_RegWrite = 1; hz.EX_Rs = 5'd2;
    @(negedge clk);
    chk("loaduse_exfwd_wb", 32'(hz.EX_FwdRs), 32'(FWD_WB));
    chk("loaduse_cnt", 32'(hz.StallCount), 32'(expCnt));

    // $3 in MEM and WB: MEM wins
    nextCycle();
    hz.MEM_RtRd = 5'd3; hz.MEM_RegWrite = 1;
    hz.WB_RtRd = 5'd3;  hz.WB_RegWrite = 1;
    hz.EX_Rs = 5'd3; hz.EX_Rt = 5'd5; hz.ID_Rs = 5'd3;
    @(negedge clk);
    chk("fwd_ex_mem_prio", 32'(hz.EX_FwdRs), 32'(FWD_MEM));
    chk("fwd_ex_nomatch", 32'(hz.EX_FwdRt), 32'(FWD_RF));
    chk("fwd_id_mem_prio", 32'(hz.ID_FwdRs), 32'(FWD_MEM));
    nextCycle();
    hz.MEM_RtRd = 5'd4; hz.MEM_RegWrite = 1;
    hz.WB_RtRd = 5'd3;  hz.WB_RegWrite = 1;
    hz.EX_Rt = 5'd3; hz.ID_Rt = 5'd4;
    @(negedge clk);
    chk("fwd_ex_wb_only", 32'(hz.EX_FwdRt), 32'(FWD_WB));
    chk("fwd_id_rt_mem", 32'(hz.ID_FwdRt), 32'(FWD_MEM));
    nextCycle();
    hz.MEM_RegWrite = 1; hz.WB_RegWrite = 1;
    @(negedge clk);
    chk("fwd_reg0_ex", 32'(hz.EX_FwdRs), 32'(FWD_RF));
    chk("fwd_reg0_id", 32'(hz.ID_FwdRt), 32'(FWD_RF));

    // Branch operand hazards
    nextCycle();
    hz.ID_NeedRsByID = 1; hz.ID_Rs = 5'd7; hz.EX_RtRd = 5'd7; hz.EX_RegWrite = 1;
    @(negedge clk);
    chkStall("branch_ex", 5'b11000);
    expCnt += 1;
    nextCycle();
    hz.ID_NeedRtByID = 1; hz.ID_Rt = 5'd9; hz.MEM_RtRd = 5'd9; hz.MEM_MemRead = 1;
    @(negedge clk);
    chkStall("branch_memload", 5'b11000);
    expCnt += 1;
    nextCycle();
    hz.ID_NeedRsByID = 1; hz.EX_RegWrite = 1; hz.EX_MemRead = 1; hz.ID_NeedRsByEX = 1;
    @(negedge clk);
    chkStall("branch_reg0", 5'b00000);
    nextCycle();
    hz.IF_MemBusy = 1;
    @(negedge clk);
    chkStall("ifbusy", 5'b10000);
    expCnt += 1;

    // DMEM busy three cycles
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      hz.MEM_MemBusy = 1;
      @(negedge clk);
      chkStall("dmem_hold", 5'b11110);
      expCnt += 1;
    end
    nextCycle();
    @(negedge clk);
    chkStall("dmem_release", 5'b00000);
    chk("dmem_cnt", 32'(hz.StallCount), 32'(expCnt));

    // MDU wait preempted by an exception
    nextCycle();
    hz.EX_ALUBusy = 1;
    @(negedge clk);
    chkStall("mdu_hold", 5'b11100);
    expCnt += 1;
    nextCycle();
    hz.EX_ALUBusy = 1; hz.Exc_Req = 1;
    @(negedge clk);
    chkStall("mdu_exc_cycle", 5'b00000);
    chkFlush("mdu_exc_noflush", 4'b0000, 1'b0);
    nextCycle();
    hz.EX_ALUBusy = 1;
    @(negedge clk);
    chkFlush("mdu_flush", 4'b1111, 1'b1);
    chkStall("mdu_flush_stall", 5'b00000);
    nextCycle();
    @(negedge clk);
    chkFlush("mdu_after_flush", 4'b0000, 1'b0);

    // Exception coincident with DMEM busy
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      hz.MEM_MemBusy = 1;
      @(negedge clk);
      expCnt += 1;
    end
    nextCycle();
    hz.MEM_MemBusy = 1; hz.Exc_Req = 1;
    @(negedge clk);
    chkStall("exc_beats_dmem", 5'b00000);
    nextCycle();
    @(negedge clk);
    chkFlush("exc_dmem_flush", 4'b1111, 1'b1);

    // DMEM timeout: 255 stalled cycles, then flush with BusErr
    for (int i = 1; i <= 255; i++) begin
      nextCycle();
      hz.MEM_MemBusy = 1;
      @(negedge clk);
      chkStall("tmo_hold", 5'b11110);
      expCnt += 1;
    end
    chk("tmo_buserr_pre", 32'(hz.BusErr), 32'd0);
    nextCycle();
    hz.MEM_MemBusy = 1;
    @(negedge clk);
    chkFlush("tmo_flush", 4'b1111, 1'b1);
    chkStall("tmo_flush_stall", 5'b00000);
    chk("tmo_buserr", 32'(hz.BusErr), 32'd1);
    nextCycle();
    @(negedge clk);
    chkFlush("tmo_after", 4'b0000, 1'b0);
    chk("tmo_buserr_sticky", 32'(hz.BusErr), 32'd1);
    chk("tmo_cnt", 32'(hz.StallCount), 32'(expCnt));

    // Async reset in the middle of a DMEM wait
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      hz.MEM_MemBusy = 1;
      @(negedge clk);
    end
    chkStall("arst_pre", 5'b11110);
    #2;
    rst = 1'b0;
    #1;
    chkStall("arst_stall", 5'b00000);
    chk("arst_buserr", 32'(hz.BusErr), 32'd0);
    chk("arst_cnt", 32'(hz.StallCount), 32'd0);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    chkStall("arst_run", 5'b00000);
    nextCycle();
    hz.ID_NeedRsByID = 1; hz.ID_Rs = 5'd6; hz.EX_RtRd = 5'd6; hz.EX_RegWrite = 1;
    @(negedge clk);
    chkStall("arst_branch", 5'b11000);
    nextCycle();
    @(negedge clk);
    chk("arst_cnt_after", 32'(hz.StallCount), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
